// File: rtl/int_res_arbiter.sv
// ---------------------------------------------------------------------------
// int_res_arbiter
//
// Purpose:
//   Shares the single-port intermediate-result CIM memory between NUM_REQ
//   requesters (index 0 = master inference FSM, then the compute datapath
//   and the EEG/ADC loader). Each granted request becomes one memory access
//   for single-width data or two for double-width data. Read data comes back
//   on a shared response bus, either sign-extended (single) or concatenated
//   from two words (double). The memory has a 1-cycle read latency.
//
//   Double-width layout: the word at A holds bits [2*DATA_W-1:DATA_W], and
//   the word at A+1 holds bits [DATA_W-1:0].
//
// Build option:
//   INT_RES_ARB_FIXED_PRIO_EN - when defined, fixed priority (lowest index
//   wins) replaces the default round-robin and no rotation pointer exists.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   req_valid       : per-requester request pending
//   req_ready       : one-hot grant, combinational in IDLE
//   req_write       : per-requester 1 = write, 0 = read
//   req_width       : per-requester 0 = single, 1 = double width
//   req_addr        : packed per-requester word addresses
//   req_wdata       : packed per-requester write data (2*DATA_W each)
//   resp_valid      : 1-cycle read-data pulse to the owning requester
//   resp_rdata      : shared read data bus
//   addr_err        : 1-cycle pulse for an out-of-range access
//   mem_en/mem_we   : memory enable / write enable
//   mem_addr        : memory word address
//   mem_wdata       : memory write data
//   mem_rdata       : memory read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module int_res_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DEPTH   = 57344,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ-1:0]          req_width,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*2*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]          resp_valid,
    output logic [2*DATA_W-1:0]         resp_rdata,
    output logic                        addr_err,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ACC1,
        ACC2,
        RDWAIT,
        ERR
    } state_t;

    state_t state_q, state_d;

    // Request captured at grant time; the requester may change its inputs
    // afterwards, so everything the access needs lives here.
    logic [IDX_W-1:0]    owner_q;
    logic                write_q;
    logic                width_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [2*DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0]   hold_q;

    logic                grant_found;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_take;

    logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
    logic [2*DATA_W-1:0] wdata_arr [NUM_REQ];
    logic [ADDR_W-1:0]   sel_addr;
    logic [31:0]         sel_addr_ext;
    logic                sel_illegal;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata[g*2*DATA_W +: 2*DATA_W];
    end

`ifdef INT_RES_ARB_FIXED_PRIO_EN
    // Fixed priority: scan from the top so the lowest valid index is the
    // last one written and therefore wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[IDX_W'(i)]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W:0]   cand;

    // Round-robin: walk the requesters starting at the pointer, wrapping
    // modulo NUM_REQ, and take the first valid one.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // The pointer moves one past each winner, including grants that end
    // in an address error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else if (grant_take) begin
            if (grant_idx == IDX_W'(NUM_REQ - 1)) begin
                rr_ptr_q <= '0;
            end else begin
                rr_ptr_q <= grant_idx + IDX_W'(1);
            end
        end
    end
`endif

    assign grant_take   = (state_q == IDLE) && grant_found;
    assign sel_addr     = addr_arr[grant_idx];
    assign sel_addr_ext = {{(32-ADDR_W){1'b0}}, sel_addr};
    // No wrap-around: a double-width access needs A+1 inside the memory too.
    assign sel_illegal  = (sel_addr_ext >= 32'(DEPTH)) ||
                          (req_width[grant_idx] && (sel_addr_ext >= 32'(DEPTH - 1)));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    state_d = sel_illegal ? ERR : ACC1;
                end
            end
            ACC1: begin
                if (width_q) begin
                    state_d = ACC2;
                end else if (write_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = RDWAIT;
                end
            end
            ACC2:    state_d = write_q ? IDLE : RDWAIT;
            RDWAIT:  state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture and the upper-half holding register. The upper half of
    // a double-width read arrives during ACC2 (one cycle after ACC1's read).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= '0;
            write_q <= 1'b0;
            width_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= '0;
        end else begin
            if (grant_take) begin
                owner_q <= grant_idx;
                write_q <= req_write[grant_idx];
                width_q <= req_width[grant_idx];
                addr_q  <= sel_addr;
                wdata_q <= wdata_arr[grant_idx];
            end
            if ((state_q == ACC2) && !write_q) begin
                hold_q <= mem_rdata;
            end
        end
    end

    // Outputs. Memory signals depend only on registered state, so a reset
    // drops them asynchronously.
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        resp_rdata = '0;
        addr_err   = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                end
            end
            ACC1: begin
                mem_en    = 1'b1;
                mem_we    = write_q;
                mem_addr  = addr_q;
                mem_wdata = width_q ? wdata_q[2*DATA_W-1:DATA_W] : wdata_q[DATA_W-1:0];
            end
            ACC2: begin
                mem_en    = 1'b1;
                mem_we    = write_q;
                mem_addr  = addr_q + ADDR_W'(1);
                mem_wdata = wdata_q[DATA_W-1:0];
            end
            RDWAIT: begin
                resp_valid[owner_q] = 1'b1;
                if (width_q) begin
                    resp_rdata = {hold_q, mem_rdata};
                end else begin
                    resp_rdata = {{DATA_W{mem_rdata[DATA_W-1]}}, mem_rdata};
                end
            end
            ERR: begin
                addr_err = 1'b1;
                if (!write_q) begin
                    resp_valid[owner_q] = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
